// File: rtl/sysctl_pkg.sv
// Shared system-controller constants and elaboration-time helpers.
// Clock frequency here also sets the GPIO debounce sample period.
package sysctl_pkg;

  localparam int unsigned SYS_CLK_HZ                = 32_000_000;
  localparam int unsigned GPIO_PRESCALE_DEFAULT     = SYS_CLK_HZ / 1000;
  localparam int unsigned GPIO_STABLE_TICKS_DEFAULT = 4;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned width_of(input int unsigned value);
    int unsigned w;
    w = clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sysctl_gpio_filter_chan.sv
// One debounce channel: 2-flop synchronizer, stability counter, output flop.
// Edge strobe flops exist only when SYSCTL_GPIO_FILTER_EDGES_EN is defined.
module sysctl_gpio_filter_chan
  import sysctl_pkg::*;
#(
  parameter int unsigned stable_ticks = GPIO_STABLE_TICKS_DEFAULT,
  parameter logic        reset_value  = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pad,
  input  logic tick,
  output logic filtered,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = width_of(stable_ticks + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(stable_ticks - 1);

  logic          sync_meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          differs;

  assign differs = (sync != filtered);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= pad;
      sync      <= sync_meta;
    end
  end

  // Any sample that agrees with the output restarts the stability count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt      <= '0;
      filtered <= reset_value;
    end else if (tick) begin
      if (!differs) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filtered <= sync;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef SYSCTL_GPIO_FILTER_EDGES_EN
  logic accept;

  assign accept = tick && differs && (cnt == CNT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept &&  sync;
      fall <= accept && !sync;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sysctl_gpio_filter.sv
// GPIO pad conditioner: shared sample-tick prescaler plus one debounce channel per input.
// Define SYSCTL_GPIO_FILTER_EDGES_EN to build the rise/fall strobe registers.
module sysctl_gpio_filter
  import sysctl_pkg::*;
#(
  parameter int unsigned          ninputs      = 16,
  parameter int unsigned          prescale     = GPIO_PRESCALE_DEFAULT,
  parameter int unsigned          stable_ticks = GPIO_STABLE_TICKS_DEFAULT,
  parameter logic [ninputs-1:0]   reset_value  = {ninputs{1'b0}}
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [ninputs-1:0] gpio_pads,
  output logic [ninputs-1:0] gpio_filtered,
  output logic [ninputs-1:0] gpio_rise,
  output logic [ninputs-1:0] gpio_fall
);

  localparam int unsigned PW = width_of(prescale);
  localparam logic [PW-1:0] PRE_LAST = PW'(prescale - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  // Tick is registered, so it is high for the cycle after the wrap; with
  // prescale of 1 the compare is always true and tick stays high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
      tick    <= 1'b0;
    end
  end

  for (genvar i = 0; i < int'(ninputs); i++) begin : g_chan
    sysctl_gpio_filter_chan #(
      .stable_ticks (stable_ticks),
      .reset_value  (reset_value[i])
    ) u_chan (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .pad       (gpio_pads[i]),
      .tick      (tick),
      .filtered  (gpio_filtered[i]),
      .rise      (gpio_rise[i]),
      .fall      (gpio_fall[i])
    );
  end

endmodule

// File: tb/tb_sysctl_gpio_filter.sv
// Directed bench for sysctl_gpio_filter with prescale=4, stable_ticks=3.
// Strobe expectations follow SYSCTL_GPIO_FILTER_EDGES_EN (zero when undefined).
module tb_sysctl_gpio_filter;

`ifdef SYSCTL_GPIO_FILTER_EDGES_EN
  localparam logic [15:0] EM    = 16'hFFFF;
  localparam int          EDGES = 1;
`else
  localparam logic [15:0] EM    = 16'h0000;
  localparam int          EDGES = 0;
`endif

  logic        sys_clk;
  logic        sys_rst_n;
  logic [15:0] gpio_pads;
  logic [15:0] gpio_filtered;
  logic [15:0] gpio_rise;
  logic [15:0] gpio_fall;

  sysctl_gpio_filter #(
    .ninputs      (16),
    .prescale     (4),
    .stable_ticks (3),
    .reset_value  (16'h0000)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .gpio_pads     (gpio_pads),
    .gpio_filtered (gpio_filtered),
    .gpio_rise     (gpio_rise),
    .gpio_fall     (gpio_fall)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] pads;
    int          cycles;
    logic [15:0] exp_filt;
    logic [15:0] exp_rise;
    logic [15:0] exp_fall;
  } vec_t;

  vec_t        vecs[10];
  int          checks   = 0;
  int          failures = 0;
  int          overlaps = 0;
  logic [15:0] rise_seen;
  logic [15:0] fall_seen;
  int          rise_cnt[16];
  int          fall_cnt[16];
  int          n;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic clear_mon();
    rise_seen = '0;
    fall_seen = '0;
    for (int i = 0; i < 16; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each rising edge.
  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge sys_clk);
      #1;
      rise_seen |= gpio_rise;
      fall_seen |= gpio_fall;
      if ((gpio_rise & gpio_fall) != 16'h0) overlaps++;
      for (int i = 0; i < 16; i++) begin
        rise_cnt[i] += int'(gpio_rise[i]);
        fall_cnt[i] += int'(gpio_fall[i]);
      end
    end
  endtask

  // After return, the next rising edge is edge 1 after release; the first
  // tick is seen by the channels at edge 5, then every 4 edges.
  task automatic do_reset(input logic [15:0] pads);
    sys_rst_n = 1'b0;
    run(3);
    gpio_pads = pads;
    sys_rst_n = 1'b1;
    clear_mon();
  endtask

  initial begin
    vecs[0] = '{16'h0001, 20, 16'h0001, 16'h0001, 16'h0000};
    vecs[1] = '{16'hA5A5, 20, 16'hA5A5, 16'hA5A4, 16'h0000};
    vecs[2] = '{16'h5A5A, 20, 16'h5A5A, 16'h5A5A, 16'hA5A5};
    vecs[3] = '{16'hFFFF, 20, 16'hFFFF, 16'hA5A5, 16'h0000};
    vecs[4] = '{16'h0000, 20, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[5] = '{16'h8001, 20, 16'h8001, 16'h8001, 16'h0000};
    vecs[6] = '{16'h0000,  5, 16'h8001, 16'h0000, 16'h0000};
    vecs[7] = '{16'h8001, 20, 16'h8001, 16'h0000, 16'h0000};
    vecs[8] = '{16'h7FFE,  4, 16'h8001, 16'h0000, 16'h0000};
    vecs[9] = '{16'h7FFE, 20, 16'h7FFE, 16'h7FFE, 16'h8001};

    sys_rst_n = 1'b0;
    gpio_pads = 16'hFFFF;
    clear_mon();
    for (int c = 0; c < 3; c++) begin
      run(1);
      check16("reset_filtered", gpio_filtered, 16'h0000);
      check16("reset_strobes", gpio_rise | gpio_fall, 16'h0000);
    end

    gpio_pads = 16'h0000;
    sys_rst_n = 1'b1;
    run(3);
    check16("tick_edge3", 16'(dut.tick), 16'h0000);
    run(1);
    check16("tick_edge4", 16'(dut.tick), 16'h0001);
    run(1);
    check16("tick_edge5", 16'(dut.tick), 16'h0000);

    // Table: each record drives a pad pattern and checks the settled output.
    run(20);
    for (int v = 0; v < 10; v++) begin
      clear_mon();
      gpio_pads = vecs[v].pads;
      run(vecs[v].cycles);
      check16($sformatf("vec%0d_filtered", v), gpio_filtered, vecs[v].exp_filt);
      check16($sformatf("vec%0d_rise", v), rise_seen, vecs[v].exp_rise & EM);
      check16($sformatf("vec%0d_fall", v), fall_seen, vecs[v].exp_fall & EM);
    end

    // Clean step: pad sampled first at edge 3, ticks at 5,9,13 -> change at 13.
    do_reset(16'h0000);
    run(2);
    gpio_pads = 16'h0001;
    n = 0;
    while (n < 20 && gpio_filtered[0] == 1'b0) begin
      run(1);
      n++;
    end
    check_range("step_latency", n - 1, 10, 13);
    check16("step_filtered", gpio_filtered, 16'h0001);
    check16("step_rise", gpio_rise, 16'h0001 & EM);
    check16("step_fall", gpio_fall, 16'h0000);
    run(1);
    check16("step_rise_drop", gpio_rise, 16'h0000);

    // Short glitch: six samples cover only two ticks.
    do_reset(16'h0000);
    run(2);
    gpio_pads = 16'h0008;
    run(6);
    gpio_pads = 16'h0000;
    run(30);
    check16("glitch6_filtered", gpio_filtered, 16'h0000);
    check16("glitch6_rise", rise_seen, 16'h0000);

    // Nine samples aligned to ticks 5,9,13: one rise at edge 13, fall at 25.
    do_reset(16'h0000);
    run(2);
    gpio_pads = 16'h0008;
    run(9);
    gpio_pads = 16'h0000;
    run(1);
    check16("glitch9_edge12", gpio_filtered, 16'h0000);
    run(1);
    check16("glitch9_edge13", gpio_filtered, 16'h0008);
    check16("glitch9_rise", gpio_rise, 16'h0008 & EM);
    run(30);
    check16("glitch9_final", gpio_filtered, 16'h0000);
    check_range("glitch9_rise_cnt", rise_cnt[3], EDGES, EDGES);
    check_range("glitch9_fall_cnt", fall_cnt[3], EDGES, EDGES);

    // Bounce: 4-cycle half periods never span more than one tick.
    do_reset(16'h0000);
    for (int h = 0; h < 10; h++) begin
      gpio_pads = (h % 2 == 0) ? 16'h0020 : 16'h0000;
      run(4);
      check16($sformatf("bounce_hold%0d", h), gpio_filtered, 16'h0000);
    end
    gpio_pads = 16'h0020;
    run(60);
    check16("bounce_final", gpio_filtered, 16'h0020);
    check_range("bounce_rise_cnt", rise_cnt[5], EDGES, EDGES);
    check_range("bounce_fall_cnt", fall_cnt[5], 0, 0);

    // Simultaneous rise on channel 1 and fall on channel 2.
    do_reset(16'h0000);
    gpio_pads = 16'h0004;
    run(20);
    check16("simul_start", gpio_filtered, 16'h0004);
    gpio_pads = 16'h0002;
    n = 0;
    while (n < 20 && gpio_filtered == 16'h0004) begin
      run(1);
      n++;
    end
    check_range("simul_latency", n - 1, 10, 13);
    check16("simul_filtered", gpio_filtered, 16'h0002);
    check16("simul_rise", gpio_rise, 16'h0002 & EM);
    check16("simul_fall", gpio_fall, 16'h0004 & EM);

    // Reset two ticks into a debounce of bit 0 (ticks at 25, 29).
    do_reset(16'h0100);
    run(20);
    check16("midrst_pre", gpio_filtered, 16'h0100);
    gpio_pads = 16'h0101;
    run(9);
    check16("midrst_nochange", gpio_filtered, 16'h0100);
    sys_rst_n = 1'b0;
    #1;
    check16("midrst_async", gpio_filtered, 16'h0000);
    check16("midrst_strobes", gpio_rise | gpio_fall, 16'h0000);
    run(3);
    sys_rst_n = 1'b1;
    run(12);
    check16("midrst_edge12", gpio_filtered, 16'h0000);
    run(1);
    check16("midrst_edge13", gpio_filtered, 16'h0101);
    check16("midrst_rise", gpio_rise, 16'h0101 & EM);

    check_range("rise_fall_overlap", overlaps, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sysctl_gpio_filter.md
# sysctl_gpio_filter

Pad-side input conditioner placed directly upstream of the system controller's GPIO inputs. It synchronizes raw button/DIP-switch pad levels, debounces each channel with a shared prescaled sample tick and a per-channel stability counter, and drives the clean levels into the controller's `gpio_inputs`. Optional one-cycle rise/fall strobes are provided for consumers that need edge events without running their own change detection.

## Interface
- `ninputs`, 16: number of channels.
- `prescale`, 32000: sample tick period in `sys_clk` cycles, P; must be ≥1. The default gives 1 ms at 32 MHz.
- `stable_ticks`, 4: consecutive differing samples required to accept a new level, S; must be ≥1.
- `reset_value`, {ninputs{1'b0}}: value of `gpio_filtered` during and after reset.

- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `gpio_pads`  in  ninputs  raw asynchronous pad levels.
- `gpio_filtered`  out  ninputs  debounced levels; connects to the system controller's `gpio_inputs`.
- `gpio_rise`  out  ninputs  one-cycle strobe per channel on a 0→1 change of `gpio_filtered`.
- `gpio_fall`  out  ninputs  one-cycle strobe per channel on a 1→0 change of `gpio_filtered`.

## Operation
- **Reset.** One clock; reset is asynchronous and active-low. While `sys_rst_n`=0:
  - `gpio_filtered`=`reset_value`; `gpio_rise`=`gpio_fall`=0.
  - Sync flops, prescaler and all stability counters are cleared to 0.
- **Synchronizer.** Two flops per channel; `sync` is the second stage.
- **Prescaler.**
  - Counter width is clog2(P), minimum 1. It counts 0..P-1 and wraps to 0.
  - Registered `tick` is high for the one cycle after the counter wraps, so the first tick occurs P cycles after reset release.
  - When P=1, `tick` is high every cycle.
- **Per-channel counter.** Width is clog2(S+1). On each edge with `tick`=1:
  - `sync`==`gpio_filtered`: counter←0.
  - `sync`≠`gpio_filtered` and counter==S-1: `gpio_filtered`←`sync`, counter←0.
  - Otherwise: counter←counter+1.
  - On edges with `tick`=0, the counter holds.
- **Sampling behaviour.** Glitches that fall entirely between ticks are never seen. Any tick that sees `sync` agree with the current output restarts the count.
- **Edge strobes.**
  - `gpio_rise[i]` and `gpio_fall[i]` are registered and assert in the same cycle that `gpio_filtered[i]` changes.
  - Each deasserts on the next edge.
  - At most one of the two is high per channel.
- **Channel independence.** Channels are fully independent. Any number of channels may change, in either direction, in the same cycle.

## Timing
- Latency runs from the first `sys_clk` edge that samples a new, stable pad level to the change of `gpio_filtered`.
  - Minimum: 2+(S-1)·P edges. Maximum: 1+S·P edges.
  - Example: P=4, S=3 gives 10..13.
- Strobes have zero added latency relative to `gpio_filtered`.
- A pad pulse covering fewer than S ticks never propagates.
- **Reset mid-operation:** outputs return to `reset_value` immediately (asynchronously). The prescaler phase restarts from 0.
- No counter can overflow: it saturates logically at S-1 by rule.

## Configuration
- `SYSCTL_GPIO_FILTER_EDGES_EN` defined: the edge strobe registers are built as described.
- Undefined:
  - `gpio_rise` and `gpio_fall` are tied to 0.
  - No strobe flops exist.
  - `gpio_filtered` behaviour is unchanged.

## Structure
- **Shared package** `sysctl_pkg`:
  - clog2 helper function.
  - Default prescale and stable-tick constants, shared with the system controller's clock-frequency parameter.
- **Sub-module** `sysctl_gpio_filter_chan`: one channel, containing the synchronizer, stability counter, output flop and strobes. It is instantiated `ninputs` times by a generate loop.
- The top level holds only the prescaler and the instances.

## Test plan
All scenarios use P=4, S=3 and `reset_value`=0 unless stated.
- **Reset values.** Hold `sys_rst_n`=0 with pads=16'hFFFF → `gpio_filtered`=0 and strobes=0 throughout. Release → first `tick` 4 cycles later.
- **Clean step.** `gpio_pads[0]` 0→1 and held → `gpio_filtered[0]`=1 within 10..13 edges. `gpio_rise[0]` is high for exactly that one cycle. `gpio_fall`=0.
- **Glitch rejection.** `gpio_pads[3]`=1 for 6 cycles, then 0 → `gpio_filtered[3]` stays 0 and no strobe fires. Repeat with 9 cycles aligned to cover 3 ticks → one rise.
- **Bouncing.** Toggle `gpio_pads[5]` every 4 cycles for 40 cycles, then hold 1 → exactly one `gpio_rise[5]`, no `gpio_fall[5]`; final level is 1.
- **Simultaneous events.** From `gpio_filtered`=16'h0004, drive pads=16'h0002 → `gpio_rise[1]` and `gpio_fall[2]` assert in the same cycle. `gpio_filtered` becomes 16'h0002.
- **Reset mid-count.** Assert `sys_rst_n`=0 two ticks into a 0→1 debounce → no change occurs. After release, the full 10..13-edge latency is required again. Build once without `SYSCTL_GPIO_FILTER_EDGES_EN` and check that the strobes stay 0.
